// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter: operation encoding and FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SLT = 3'b110,
        OP_EQ  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } arb_state_e;

endpackage

// File: rtl/alu4_core.sv
// Purely combinational ALU datapath: result, carry, zero and signed-overflow flags.
module alu4_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic             zero_o,
    output logic             ovf_o
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sumFull;
    logic [WIDTH:0]   diffFull;
    logic             addOvf;
    logic             subOvf;
    logic             lessThan;
    logic             equal;
    logic [WIDTH-1:0] result;

    // Subtraction is x + ~y + 1 so the top bit is the "no borrow" carry.
    assign sumFull  = {1'b0, x_i} + {1'b0, y_i};
    assign diffFull = {1'b0, x_i} + {1'b0, ~y_i} + {{WIDTH{1'b0}}, 1'b1};
    assign addOvf   = (x_i[MSB] == y_i[MSB]) && (sumFull[MSB] != x_i[MSB]);
    assign subOvf   = (x_i[MSB] != y_i[MSB]) && (diffFull[MSB] != x_i[MSB]);
    assign lessThan = diffFull[MSB] ^ subOvf;
    assign equal    = (x_i == y_i);

    always_comb begin
        result = '0;
        c_o    = 1'b0;
        ovf_o  = 1'b0;
        case (alu_op_e'(op_i))
            OP_ADD: begin
                result = sumFull[WIDTH-1:0];
                c_o    = sumFull[WIDTH];
                ovf_o  = addOvf;
            end
            OP_SUB: begin
                result = diffFull[WIDTH-1:0];
                c_o    = diffFull[WIDTH];
                ovf_o  = subOvf;
            end
            OP_NOT:  result = ~x_i;
            OP_AND:  result = x_i & y_i;
            OP_OR:   result = x_i | y_i;
            OP_XOR:  result = x_i ^ y_i;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, lessThan};
            OP_EQ:   result = {{(WIDTH-1){1'b0}}, equal};
            default: result = '0;
        endcase
    end

    assign s_o    = result;
    assign zero_o = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a registered
// result channel held until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_s,
    output logic             resp_c,
    output logic             resp_zero,
    output logic             resp_ovf
);

    arb_state_e       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             id_q, id_d;
    logic             respValid_q, respValid_d;
    logic             respId_q, respId_d;
    logic [WIDTH-1:0] respS_q, respS_d;
    logic             respC_q, respC_d;
    logic             respZero_q, respZero_d;
    logic             respOvf_q, respOvf_d;

    logic             anyValid;
    logic             grantId;
    logic [WIDTH-1:0] coreS;
    logic             coreC;
    logic             coreZero;
    logic             coreOvf;

    alu4_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i   (op_q),
        .x_i    (x_q),
        .y_i    (y_q),
        .s_o    (coreS),
        .c_o    (coreC),
        .zero_o (coreZero),
        .ovf_o  (coreOvf)
    );

    // The pointer only breaks ties; a lone requester always wins.
    assign anyValid = req0_valid | req1_valid;
    assign grantId  = (req0_valid && req1_valid) ? ptr_q : req1_valid;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        id_d        = id_q;
        respValid_d = respValid_q;
        respId_d    = respId_q;
        respS_d     = respS_q;
        respC_d     = respC_q;
        respZero_d  = respZero_q;
        respOvf_d   = respOvf_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (anyValid && rst_n) begin
                    req0_ready = ~grantId;
                    req1_ready = grantId;
                    op_d       = grantId ? req1_op : req0_op;
                    x_d        = grantId ? req1_x  : req0_x;
                    y_d        = grantId ? req1_y  : req0_y;
                    id_d       = grantId;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                respS_d     = coreS;
                respC_d     = coreC;
                respZero_d  = coreZero;
                respOvf_d   = coreOvf;
                respId_d    = id_q;
                respValid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (resp_ready) begin
                    respValid_d = 1'b0;
                    ptr_d       = ~id_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            op_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            id_q        <= 1'b0;
            respValid_q <= 1'b0;
            respId_q    <= 1'b0;
            respS_q     <= '0;
            respC_q     <= 1'b0;
            respZero_q  <= 1'b0;
            respOvf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            id_q        <= id_d;
            respValid_q <= respValid_d;
            respId_q    <= respId_d;
            respS_q     <= respS_d;
            respC_q     <= respC_d;
            respZero_q  <= respZero_d;
            respOvf_q   <= respOvf_d;
        end
    end

    assign resp_valid = respValid_q;
    assign resp_id    = respId_q;
    assign resp_s     = respS_q;
    assign resp_c     = respC_q;
    assign resp_zero  = respZero_q;
    assign resp_ovf   = respOvf_q;

endmodule
